// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bundles the signals of the load/store unit's three
// sides: the execute-stage request handshake, the data-memory
// request/acknowledge port and the writeback/status pulses.
//   slave  : used by load_store_unit. It accepts requests from execute,
//            drives the memory port and reports completion.
//   master : used by the environment, meaning the execute stage, the
//            memory and writeback.
interface load_store_unit_if;
    // execute-stage request handshake
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    // data-memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    // completion / writeback
    logic        done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_cause;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_store, req_funct3, req_rd,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata,
        output done, wb_valid, wb_rd, wb_data, err, err_cause
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_store, req_funct3, req_rd,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata,
        input  done, wb_valid, wb_rd, wb_data, err, err_cause
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage.
// - Takes the ALU result as the effective address.
// - Issues one word-aligned request/acknowledge memory access per operation.
// - Aligns and extends load data for writeback.
// - Reports completion through single-cycle done/err pulses.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : load_store_unit_if.slave (request handshake, memory port, writeback)
// Parameter:
//   TIMEOUT_CYCLES (1..255) : REQ cycles without mem_ack before a timeout
// Build option:
//   LSU_MISALIGN_TRAP_EN : when this is defined, misaligned halfword/word
//   requests are rejected with cause 01. Without it, they access the
//   enclosing aligned unit.
//
// state | meaning
// IDLE  | ready for a request; accepting registers it
// REQ   | memory request outstanding, wait counter running
// RESP  | one-cycle completion: done, err, wb_* valid
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;

    logic [31:0] maddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [1:0]  cause_q;
    logic [31:0] ld_data_q;

    // Decode of the presented request (only meaningful in the accepting cycle)
    logic [1:0]  dec_off;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic [1:0]  dec_cause;
    logic        accept;

    assign accept = (state == S_IDLE) && bus.req_valid;

    always_comb begin
        dec_off   = 2'b00;
        dec_be    = 4'b1111;
        dec_wdata = bus.req_wdata;
        dec_cause = 2'b00;
        case (bus.req_funct3)
            3'b000, 3'b100: begin
                dec_off   = bus.req_addr[1:0];
                dec_be    = 4'b0001 << bus.req_addr[1:0];
                dec_wdata = {4{bus.req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                // halfword lane selected by addr[1]; addr[0] is never a shift
                dec_off   = {bus.req_addr[1], 1'b0};
                dec_be    = 4'b0011 << {bus.req_addr[1], 1'b0};
                dec_wdata = {2{bus.req_wdata[15:0]}};
`ifdef LSU_MISALIGN_TRAP_EN
                if (bus.req_addr[0]) dec_cause = 2'b01;
`endif
            end
            3'b010: begin
`ifdef LSU_MISALIGN_TRAP_EN
                if (bus.req_addr[1:0] != 2'b00) dec_cause = 2'b01;
`endif
            end
            default: dec_cause = 2'b11;
        endcase
        // stores have no unsigned variants; illegal outranks misalignment
        if (bus.req_store && (bus.req_funct3 >= 3'b011)) dec_cause = 2'b11;
    end

    // Load data alignment and extension
    logic [31:0] shifted;
    logic [31:0] ld_ext;

    always_comb begin
        shifted = bus.mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_ext = {24'd0, shifted[7:0]};
            3'b101:  ld_ext = {16'd0, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = (dec_cause != 2'b00) ? S_RESP : S_REQ;
            end
            S_REQ: begin
                // ack takes priority over a coincident timeout
                if (bus.mem_ack || (wait_cnt == WAIT_LAST)) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request registers, wait counter and load capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maddr_q   <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            store_q   <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            rd_q      <= '0;
            cause_q   <= '0;
            ld_data_q <= '0;
            wait_cnt  <= '0;
        end else if (accept) begin
            maddr_q   <= {bus.req_addr[31:2], 2'b00};
            wdata_q   <= dec_wdata;
            be_q      <= dec_be;
            store_q   <= bus.req_store;
            f3_q      <= bus.req_funct3;
            off_q     <= dec_off;
            rd_q      <= bus.req_rd;
            cause_q   <= dec_cause;
            ld_data_q <= '0;
            wait_cnt  <= '0;
        end else if (state == S_REQ) begin
            if (bus.mem_ack) begin
                if (!store_q) ld_data_q <= ld_ext;
            end else begin
                if (wait_cnt == WAIT_LAST) cause_q <= 2'b10;
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // FSM outputs
    always_comb begin
        bus.req_ready = (state == S_IDLE);
        bus.mem_req   = (state == S_REQ);
        bus.mem_we    = (state == S_REQ) && store_q;
        bus.mem_addr  = (state == S_REQ) ? maddr_q : 32'd0;
        bus.mem_be    = (state == S_REQ) ? be_q    : 4'd0;
        bus.mem_wdata = (state == S_REQ && store_q) ? wdata_q : 32'd0;
        bus.done      = (state == S_RESP);
        bus.err       = (state == S_RESP) && (cause_q != 2'b00);
        bus.err_cause = (state == S_RESP) ? cause_q : 2'b00;
        bus.wb_valid  = (state == S_RESP) && !store_q && (cause_q == 2'b00) && (rd_q != 5'd0);
        bus.wb_rd     = (state == S_RESP) ? rd_q : 5'd0;
        bus.wb_data   = ((state == S_RESP) && !store_q && (cause_q == 2'b00)) ? ld_data_q : 32'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- specification-level model ----------------
    function automatic logic [1:0] m_cause(input logic st, input logic [2:0] f3, input logic [31:0] a);
        if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b11;
        if (st && f3 >= 3'd3) return 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3[1:0] == 2'd1 && a[0]) return 2'b01;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 2'b01;
`else
        if (a[0] === 1'bx) return 2'b00;
`endif
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'd0) return 4'(1 << int'(a[1:0]));
        if (f3[1:0] == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] w);
        if (f3[1:0] == 2'd0) return {4{w[7:0]}};
        if (f3[1:0] == 2'd1) return {2{w[15:0]}};
        return w;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int off;
        logic [31:0] s, b, h;
        if (f3[1:0] == 2'd0)      off = int'(a[1:0]);
        else if (f3[1:0] == 2'd1) off = a[1] ? 2 : 0;
        else                      off = 0;
        s = d >> (8 * off);
        b = s & 32'h0000_00FF;
        h = s & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return s;
        endcase
    endfunction

    // ---------------- expected outputs for the current cycle ----------------
    logic        chk_en = 1'b0;
    logic        e_ready, e_req, e_we, e_done, e_err, e_wbv, e_chk_wbd;
    logic [31:0] e_addr, e_wdata, e_wbd;
    logic [3:0]  e_be;
    logic [1:0]  e_cause;
    logic [4:0]  e_wbrd;

    task automatic set_idle();
        e_ready = 1'b1; e_req = 1'b0; e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
        e_wbv = 1'b0; e_chk_wbd = 1'b0; e_cause = 2'b00;
        e_addr = '0; e_wdata = '0; e_be = '0; e_wbd = '0; e_wbrd = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
            chk("mem_req",   32'(bus.mem_req),   32'(e_req));
            chk("done",      32'(bus.done),      32'(e_done));
            chk("err",       32'(bus.err),       32'(e_err));
            chk("err_cause", 32'(bus.err_cause), 32'(e_cause));
            chk("wb_valid",  32'(bus.wb_valid),  32'(e_wbv));
            if (e_req) begin
                chk("mem_we",   32'(bus.mem_we), 32'(e_we));
                chk("mem_addr", bus.mem_addr,    e_addr);
                chk("mem_be",   32'(bus.mem_be), 32'(e_be));
                if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
            end
            if (e_wbv)     chk("wb_rd",   32'(bus.wb_rd), 32'(e_wbrd));
            if (e_chk_wbd) chk("wb_data", bus.wb_data,    e_wbd);
        end
    end

    // observations from the last operation, for literal checks
    logic [31:0] o_addr, o_wdata, o_wbd;
    logic [3:0]  o_be;
    logic        o_we, o_wbv, o_done;
    logic [4:0]  o_wbrd;
    logic [1:0]  o_cause;
    int          o_nreq;

    // Runs one operation from an idle cycle (called at posedge+1) and leaves
    // the bench at posedge+1 of the following idle cycle.
    // ack_at: REQ-cycle index carrying mem_ack, or -1 for no ack.
    task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic st,
                          input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdata, input int ack_at);
        logic [1:0] cause;
        bit         fin;
        int         k;
        cause  = m_cause(st, f3, a);
        o_nreq = 0;
        set_idle();
        bus.mem_ack    = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_rd     = rd;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_store  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_rd     = 5'($urandom);
        if (cause == 2'b00) begin
            fin = 1'b0;
            k   = 0;
            while (!fin) begin
                e_ready = 1'b0; e_req = 1'b1; e_we = st;
                e_addr  = {a[31:2], 2'b00}; e_be = m_be(f3, a); e_wdata = m_wd(f3, wd);
                bus.mem_ack   = (k == ack_at);
                bus.mem_rdata = (k == ack_at) ? rdata : $urandom;
                @(negedge clk);
                o_addr = bus.mem_addr; o_be = bus.mem_be; o_wdata = bus.mem_wdata; o_we = bus.mem_we;
                if (bus.mem_req) o_nreq++;
                @(posedge clk); #1;
                if (k == ack_at) fin = 1'b1;
                else if (k == TO - 1) begin fin = 1'b1; cause = 2'b10; end
                k++;
            end
            bus.mem_ack = 1'b0;
        end
        e_ready = 1'b0; e_req = 1'b0; e_we = 1'b0;
        e_done  = 1'b1; e_err = (cause != 2'b00); e_cause = cause;
        e_wbv   = !st && cause == 2'b00 && rd != 5'd0;
        e_wbrd  = rd;
        e_chk_wbd = !st || cause != 2'b00;
        e_wbd   = (cause != 2'b00) ? 32'd0 : m_ld(f3, a, rdata);
        @(negedge clk);
        o_wbd = bus.wb_data; o_wbv = bus.wb_valid; o_wbrd = bus.wb_rd;
        o_cause = bus.err_cause; o_done = bus.done;
        @(posedge clk); #1;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_store = 0;
        bus.req_funct3 = 0; bus.req_rd = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        set_idle();
        repeat (2) @(negedge clk);
        chk("rst_ready",    32'(bus.req_ready), 32'd1);
        chk("rst_mem_req",  32'(bus.mem_req),   32'd0);
        chk("rst_done",     32'(bus.done),      32'd0);
        chk("rst_err",      32'(bus.err),       32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid),  32'd0);
        chk("rst_wb_data",  bus.wb_data,        32'd0);
        chk("rst_mem_be",   32'(bus.mem_be),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // LB, ack on the first REQ cycle
        run_op(32'h0000_1003, 32'h0, 1'b0, 3'b000, 5'd5, 32'h80FF_1234, 0);
        chk("lb_addr",  o_addr, 32'h0000_1000);
        chk("lb_be",    32'(o_be), 32'(4'b1000));
        chk("lb_wbv",   32'(o_wbv), 32'd1);
        chk("lb_wbrd",  32'(o_wbrd), 32'd5);
        chk("lb_wbd",   o_wbd, 32'hFFFF_FF80);

        // LHU, ack after two wait cycles
        run_op(32'h0000_2002, 32'h0, 1'b0, 3'b101, 5'd7, 32'hBEEF_0000, 2);
        chk("lhu_be",  32'(o_be), 32'(4'b1100));
        chk("lhu_wbd", o_wbd, 32'h0000_BEEF);

        // SB
        run_op(32'h0000_0011, 32'hAABB_CCDD, 1'b1, 3'b000, 5'd3, 32'h0, 0);
        chk("sb_we",    32'(o_we), 32'd1);
        chk("sb_be",    32'(o_be), 32'(4'b0010));
        chk("sb_wdata", o_wdata, 32'hDDDD_DDDD);
        chk("sb_done",  32'(o_done), 32'd1);
        chk("sb_wbv",   32'(o_wbv), 32'd0);

        // SW with no ack: timeout
        run_op(32'h0000_0040, 32'h1234_5678, 1'b1, 3'b010, 5'd0, 32'h0, -1);
        chk("to_nreq",  32'(o_nreq), 32'd4);
        chk("to_cause", 32'(o_cause), 32'd2);

        // LW at 0x6
        run_op(32'h0000_0006, 32'h0, 1'b0, 3'b010, 5'd9, 32'h1234_5678, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw6_cause", 32'(o_cause), 32'd1);
        chk("lw6_nreq",  32'(o_nreq), 32'd0);
`else
        chk("lw6_addr",  o_addr, 32'h0000_0004);
        chk("lw6_wbd",   o_wbd, 32'h1234_5678);
`endif

        // LH sign extension, upper lane
        run_op(32'h0000_3002, 32'h0, 1'b0, 3'b001, 5'd12, 32'h8000_1111, 1);
        chk("lh_wbd", o_wbd, 32'hFFFF_8000);
        // LBU byte 1
        run_op(32'h0000_4001, 32'h0, 1'b0, 3'b100, 5'd13, 32'h0000_AB00, 0);
        chk("lbu_wbd", o_wbd, 32'h0000_00AB);
        // LB to x0: no writeback
        run_op(32'h0000_4000, 32'h0, 1'b0, 3'b000, 5'd0, 32'h0000_0011, 0);
        chk("x0_wbv", 32'(o_wbv), 32'd0);
        // illegal load / store funct3
        run_op(32'h0000_5000, 32'h0, 1'b0, 3'b011, 5'd4, 32'h0, 0);
        chk("ill_ld_cause", 32'(o_cause), 32'd3);
        chk("ill_ld_nreq",  32'(o_nreq), 32'd0);
        run_op(32'h0000_5000, 32'h0, 1'b1, 3'b100, 5'd4, 32'h0, 0);
        chk("ill_st_cause", 32'(o_cause), 32'd3);
        // SH upper half
        run_op(32'h0000_0022, 32'h1234_ABCD, 1'b1, 3'b001, 5'd0, 32'h0, 0);
        chk("sh_be",    32'(o_be), 32'(4'b1100));
        chk("sh_wdata", o_wdata, 32'hABCD_ABCD);
        // ack on the last allowed cycle wins over timeout
        run_op(32'h0000_0100, 32'h0, 1'b0, 3'b010, 5'd31, 32'hCAFE_F00D, TO - 1);
        chk("lastack_cause", 32'(o_cause), 32'd0);
        chk("lastack_wbd",   o_wbd, 32'hCAFE_F00D);
        // odd halfword address
        run_op(32'h0000_0005, 32'h0, 1'b0, 3'b001, 5'd2, 32'h0000_F0F0, 0);
        // SB to byte 3, then some other mixes
        run_op(32'h0000_0003, 32'h0000_0077, 1'b1, 3'b000, 5'd0, 32'h0, 1);
        chk("sb3_be", 32'(o_be), 32'(4'b1000));
        run_op(32'h0000_0007, 32'h0, 1'b0, 3'b100, 5'd1, 32'h9A00_0000, 0);
        run_op(32'h0000_0008, 32'h0, 1'b0, 3'b111, 5'd1, 32'h0, 0);
        run_op(32'h0000_0009, 32'h0, 1'b0, 3'b101, 5'd1, 32'hFFFF_8001, 0);

        // reset while in REQ
        chk_en = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0200; bus.req_store = 1'b0;
        bus.req_funct3 = 3'b010; bus.req_rd = 5'd6;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_mem_req_before", 32'(bus.mem_req), 32'd1);
        #2 rst = 1'b1;
        #1 chk("mid_mem_req_after", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_ack_done", 32'(bus.done), 32'd0);
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        set_idle();
        run_op(32'h0000_0300, 32'h0, 1'b0, 3'b010, 5'd8, 32'h0BAD_BEEF, 0);
        chk("recover_wbd", o_wbd, 32'h0BAD_BEEF);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
